inst_prefetch_queue: RTL and testbench

- Fetch-side buffer between instruction memory and the instruction decoder.
- Generates sequential 19-bit word fetch addresses and issues them to instruction memory over a req/ack handshake, one request outstanding at most.
- Buffers returned instructions with their PC in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Flushes on control-flow redirects (branch, jump, call, ret) coming from the PC logic.

---
 rtl/inst_prefetch_queue.sv | 134 +++++++++++++
 tb/tb_inst_prefetch_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over req/ack, FIFO to the decoder, flush on redirect.
// Optional PFQ_FLUSH_COUNT_EN adds a saturating flush_count output.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [18:0] RESET_PC = 19'h00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [18:0] imem_addr,
  input  logic        imem_ack,
  input  logic [18:0] imem_rdata,
  input  logic        redirect,
  input  logic [18:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [18:0] inst_out,
  output logic [18:0] inst_pc
`ifdef PFQ_FLUSH_COUNT_EN
  ,
  output logic [15:0] flush_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // state | meaning
  // IDLE  | no request outstanding; issue when the FIFO has a free slot
  // WAIT  | request outstanding, response will be enqueued
  // DROP  | request outstanding, response is stale and will be discarded
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [18:0]   fetch_pc_q, fetch_pc_d;
  logic [18:0]   req_addr_q;
  logic          issue, push, pop;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [18:0]   data_mem [DEPTH];
  logic [18:0]   pc_mem   [DEPTH];

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = req_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_out   = inst_valid ? data_mem[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;
  assign pop        = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q != FULL) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 19'd1;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (issue) req_addr_q <= fetch_pc_q;
    end
  end

  // Redirect wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

`ifdef PFQ_FLUSH_COUNT_EN
  // A redirect in DROP discards nothing new, so only WAIT or a non-empty FIFO counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_count <= '0;
    end else if (redirect && (inst_valid || state_q == WAIT) && flush_count != 16'hFFFF) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed vector table, hand sequences,
// and randomized traffic against a sequential-stream reference model.
module tb_inst_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [18:0] RESET_PC = 19'h00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [18:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [18:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [18:0] inst_out;
  logic [18:0] inst_pc;
`ifdef PFQ_FLUSH_COUNT_EN
  logic [15:0] flush_count;
`endif

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc)
`ifdef PFQ_FLUSH_COUNT_EN
    , .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is sequential from the last redirect target,
  // each entry carrying whatever the memory returned for that address.
  typedef struct packed { logic [18:0] pc; logic [18:0] data; } ent_t;
  ent_t        exp_q[$];
  logic [18:0] dlv[$];
  logic [18:0] next_pc, cur_addr;
  bit          prev_req, stale;
  int          age, cur_lat, mem_lat, acks;

  function automatic logic [18:0] mem_fn(input logic [18:0] a);
    return a + 19'h00100;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    next_pc  = RESET_PC;
    prev_req = 0;
    stale    = 0;
    age      = 0;
    cur_lat  = 0;
    acks     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 0; redirect = 0; inst_ready = 0; imem_rdata = '0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  // Called at a negedge: check outputs, drive this cycle's inputs, advance the model.
  task automatic cyc(input bit rdy, input bit redir, input logic [18:0] rpc);
    bit ack, fresh, pop;
    if (imem_req && !prev_req) begin
      cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      age     = 0;
      stale   = 0;
      chk("req_addr", imem_addr, next_pc);
      chk("credit", exp_q.size() < DEPTH, 1);
      cur_addr = imem_addr;
    end else if (imem_req) begin
      chk("addr_stable", imem_addr, cur_addr);
    end
    chk("valid", inst_valid, exp_q.size() != 0);
    ack = imem_req && (age >= cur_lat);
    pop = inst_valid && rdy && !redir;
    if (pop && exp_q.size() != 0) begin
      chk("pop_pc", inst_pc, exp_q[0].pc);
      chk("pop_data", inst_out, exp_q[0].data);
      dlv.push_back(inst_pc);
      void'(exp_q.pop_front());
    end
    fresh = ack && !stale && !redir;
    if (fresh) begin
      exp_q.push_back('{pc: next_pc, data: mem_fn(imem_addr)});
      next_pc = next_pc + 19'd1;
      acks++;
    end
    if (redir) begin
      exp_q.delete();
      next_pc = rpc;
      if (imem_req) stale = 1;
    end
    imem_ack    = ack;
    imem_rdata  = ack ? mem_fn(imem_addr) : 19'($urandom);
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    prev_req    = imem_req && !ack;
    if (imem_req) age++;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic ack; logic [18:0] rdata; logic redir; logic [18:0] rpc; logic rdy;
    logic req; logic [18:0] addr; logic valid; logic [18:0] pc; logic [18:0] out;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic [18:0] rdata, input logic redir,
                              input logic [18:0] rpc, input logic rdy, input logic req,
                              input logic [18:0] addr, input logic valid, input logic [18:0] pc,
                              input logic [18:0] out);
    return '{ack: ack, rdata: rdata, redir: redir, rpc: rpc, rdy: rdy,
             req: req, addr: addr, valid: valid, pc: pc, out: out};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[20];
    logic [18:0] rpc;
    bit found;
    // ack rdata redir rpc rdy | req addr valid pc out
    tbl[0]  = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h0,     0, 19'h0,     19'h0);
    tbl[1]  = mk(1, 19'h100,   0, 19'h0,     1, 1, 19'h0,     0, 19'h0,     19'h0);
    tbl[2]  = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h0,     1, 19'h0,     19'h100);
    tbl[3]  = mk(1, 19'h101,   0, 19'h0,     0, 1, 19'h1,     0, 19'h0,     19'h0);
    tbl[4]  = mk(0, 19'h0,     0, 19'h0,     0, 0, 19'h1,     1, 19'h1,     19'h101);
    tbl[5]  = mk(1, 19'h102,   0, 19'h0,     0, 1, 19'h2,     1, 19'h1,     19'h101);
    tbl[6]  = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h2,     1, 19'h1,     19'h101);
    tbl[7]  = mk(1, 19'h103,   1, 19'h400,   1, 1, 19'h3,     1, 19'h2,     19'h102);
    tbl[8]  = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h3,     0, 19'h0,     19'h0);
    tbl[9]  = mk(0, 19'h0,     0, 19'h0,     1, 1, 19'h400,   0, 19'h0,     19'h0);
    tbl[10] = mk(0, 19'h0,     1, 19'h7FFFE, 1, 1, 19'h400,   0, 19'h0,     19'h0);
    tbl[11] = mk(1, 19'h500,   0, 19'h0,     1, 1, 19'h400,   0, 19'h0,     19'h0);
    tbl[12] = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h400,   0, 19'h0,     19'h0);
    tbl[13] = mk(1, 19'h12345, 0, 19'h0,     1, 1, 19'h7FFFE, 0, 19'h0,     19'h0);
    tbl[14] = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h7FFFE, 1, 19'h7FFFE, 19'h12345);
    tbl[15] = mk(1, 19'h00001, 0, 19'h0,     1, 1, 19'h7FFFF, 0, 19'h0,     19'h0);
    tbl[16] = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h7FFFF, 1, 19'h7FFFF, 19'h00001);
    tbl[17] = mk(0, 19'h0,     0, 19'h0,     1, 1, 19'h0,     0, 19'h0,     19'h0);
    tbl[18] = mk(1, 19'h2A,    0, 19'h0,     1, 1, 19'h0,     0, 19'h0,     19'h0);
    tbl[19] = mk(0, 19'h0,     0, 19'h0,     1, 0, 19'h0,     1, 19'h0,     19'h2A);

    // Directed table: starts on the negedge of reset release.
    do_reset();
    chk("rst_out", inst_out, 19'h0);
    chk("rst_pc", inst_pc, 19'h0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].valid);
      if (tbl[i].req || i == 0) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_out", i), inst_out, tbl[i].out);
      end
      imem_ack    = tbl[i].ack;
      imem_rdata  = tbl[i].rdata;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      inst_ready  = tbl[i].rdy;
      @(negedge clk);
    end

    // Back-pressure: exactly DEPTH responses accepted, then fetch stalls until pops.
    do_reset();
    mem_lat = 0;
    repeat (20) cyc(0, 0, 19'h0);
    chk("fill_acks", acks, DEPTH);
    chk("fill_req_low", imem_req, 0);
    dlv.delete();
    repeat (14) cyc(1, 0, 19'h0);
    chk("drain_count", dlv.size() >= DEPTH + 1, 1);
    for (int k = 0; k <= DEPTH; k++)
      if (k < dlv.size()) chk($sformatf("drain_pc%0d", k), dlv[k], 19'(k));

    // Randomized traffic with random latency, back-pressure and redirects.
    do_reset();
    mem_lat = -1;
    dlv.delete();
    for (int c = 0; c < 3000; c++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 19'h7FFFC + 19'($urandom_range(0, 3)) : 19'($urandom);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc);
    end
    chk("rand_progress", dlv.size() > 100, 1);

    // Async reset mid-request with two entries buffered.
    do_reset();
    mem_lat = 3;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (exp_q.size() == 2 && imem_req) found = 1;
      else cyc(0, 0, 19'h0);
    end
    chk("rst_setup_reached", found, 1);
    #2 reset = 1'b0;
    imem_ack = 0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_valid", inst_valid, 0);
    chk("arst_out", inst_out, 19'h0);
    chk("arst_pc", inst_pc, 19'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
    mem_lat = 0;
    cyc(1, 0, 19'h0);
    chk("rel_first_req", imem_req, 1);
    chk("rel_first_addr", imem_addr, RESET_PC);
    dlv.delete();
    repeat (6) cyc(1, 0, 19'h0);
    chk("rel_delivered", dlv.size() >= 1, 1);
    if (dlv.size() >= 1) chk("rel_first_pc", dlv[0], RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
